id_stage: RTL and testbench

Registered, parametrised RV32I decode stage that merges combinational decode with the ID/EX pipeline register. It sits between `if_id` and the execute unit. It drives register-file read addresses, builds operands and immediates for all RV32I base formats, and flags illegal encodings. It adds valid/ready handshaking, flush, and a one-bubble load-use interlock.

---
 rtl/id_stage_if.sv | 49 ++++
 rtl/id_stage.sv | 202 ++++++++++++++++++++
 tb/tb_id_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_if
// Brief    : Fetch-side, register-file and execute-side signals of id_stage.
// Revision : 1.0
// ============================================================================
interface id_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [XLEN-1:0]   inst_addr_i;
  logic [31:0]       inst_i;
  logic [REG_AW-1:0] rs1_addr_o;
  logic [REG_AW-1:0] rs2_addr_o;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [XLEN-1:0]   inst_addr_o;
  logic [31:0]       inst_o;
  logic [XLEN-1:0]   op1_o;
  logic [XLEN-1:0]   op2_o;
  logic [XLEN-1:0]   imm_o;
  logic [XLEN-1:0]   rs2_data_o;
  logic [REG_AW-1:0] rd_addr_o;
  logic              reg_wen_o;
  logic              is_load_o;
  logic              illegal_o;

  modport slave (
    input  flush_i, in_valid_i, inst_addr_i, inst_i, rs1_data_i, rs2_data_i,
           out_ready_i,
    output in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, inst_addr_o, inst_o,
           op1_o, op2_o, imm_o, rs2_data_o, rd_addr_o, reg_wen_o, is_load_o,
           illegal_o
  );

  modport master (
    output flush_i, in_valid_i, inst_addr_i, inst_i, rs1_data_i, rs2_data_i,
           out_ready_i,
    input  in_ready_o, rs1_addr_o, rs2_addr_o, out_valid_o, inst_addr_o, inst_o,
           op1_o, op2_o, imm_o, rs2_data_o, rd_addr_o, reg_wen_o, is_load_o,
           illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : RV32I decode merged with the ID/EX register, valid/ready, flush
//            and one-bubble load-use interlock.
// Revision : 1.0
// ============================================================================
module id_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic      clk,
  input  logic      rst,
  id_stage_if.slave bus
);
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_opimm  = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;

  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt, w_link;
  logic              w_rs1_used, w_rs2_used, w_writes, w_is_load, w_illegal;
  logic [XLEN-1:0]   w_imm, w_op1, w_op2;
  logic [REG_AW-1:0] w_rs1_addr, w_rs2_addr, w_rd_addr;
  logic              w_reg_wen, w_hazard, w_in_ready, w_capture;

  logic              r_out_valid;
  logic [XLEN-1:0]   r_inst_addr;
  logic [31:0]       r_inst;
  logic [XLEN-1:0]   r_op1, r_op2, r_imm, r_rs2_data;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_wen, r_is_load, r_illegal;

  assign w_opc   = bus.inst_i[6:0];
  assign w_f3    = bus.inst_i[14:12];
  assign w_f7    = bus.inst_i[31:25];
  assign w_imm_i = XLEN'($signed(bus.inst_i[31:20]));
  assign w_imm_s = XLEN'($signed({bus.inst_i[31:25], bus.inst_i[11:7]}));
  assign w_imm_b = XLEN'($signed({bus.inst_i[31], bus.inst_i[7], bus.inst_i[30:25],
                                  bus.inst_i[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({bus.inst_i[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({bus.inst_i[31], bus.inst_i[19:12], bus.inst_i[20],
                                  bus.inst_i[30:21], 1'b0}));
  assign w_shamt = XLEN'(bus.inst_i[24:20]);
  assign w_link  = XLEN'(4);

  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_writes   = 1'b0;
    w_is_load  = 1'b0;
    w_illegal  = 1'b0;
    w_imm      = '0;
    w_op1      = '0;
    w_op2      = '0;
    case (w_opc)
      c_opc_op: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_writes   = 1'b1;
        w_op1      = bus.rs1_data_i;
        w_op2      = bus.rs2_data_i;
        // funct7 0x20 only selects SUB and SRA
        w_illegal  = !((w_f7 == 7'h00) ||
                       ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      c_opc_opimm: begin
        w_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_imm      = w_imm_i;
        w_op1      = bus.rs1_data_i;
        if (w_f3 == 3'b001) begin
          w_op2     = w_shamt;
          w_illegal = (w_f7 != 7'h00);
        end else if (w_f3 == 3'b101) begin
          w_op2     = w_shamt;
          w_illegal = (w_f7 != 7'h00) && (w_f7 != 7'h20);
        end else begin
          w_op2     = w_imm_i;
        end
      end
      c_opc_load: begin
        w_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_is_load  = 1'b1;
        w_imm      = w_imm_i;
        w_op1      = bus.rs1_data_i;
        w_op2      = w_imm_i;
        w_illegal  = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
      end
      c_opc_store: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = w_imm_s;
        w_op1      = bus.rs1_data_i;
        w_op2      = w_imm_s;
        w_illegal  = (w_f3 > 3'd2);
      end
      c_opc_branch: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm      = w_imm_b;
        w_op1      = bus.rs1_data_i;
        w_op2      = bus.rs2_data_i;
        w_illegal  = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      c_opc_lui: begin
        w_writes = 1'b1;
        w_imm    = w_imm_u;
        w_op2    = w_imm_u;
      end
      c_opc_auipc: begin
        w_writes = 1'b1;
        w_imm    = w_imm_u;
        w_op1    = bus.inst_addr_i;
        w_op2    = w_imm_u;
      end
      c_opc_jal: begin
        w_writes = 1'b1;
        w_imm    = w_imm_j;
        w_op1    = bus.inst_addr_i;
        w_op2    = w_link;
      end
      c_opc_jalr: begin
        w_rs1_used = 1'b1;
        w_writes   = 1'b1;
        w_imm      = w_imm_i;
        w_op1      = bus.inst_addr_i;
        w_op2      = w_link;
        w_illegal  = (w_f3 != 3'b000);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_rs1_addr = w_rs1_used ? REG_AW'(bus.inst_i[19:15]) : '0;
  assign w_rs2_addr = w_rs2_used ? REG_AW'(bus.inst_i[24:20]) : '0;
  assign w_rd_addr  = w_writes   ? REG_AW'(bus.inst_i[11:7])  : '0;
  assign w_reg_wen  = w_writes & ~w_illegal & (w_rd_addr != '0);

  // Unused source addresses are forced to x0, so they can never match a nonzero rd
  assign w_hazard   = r_out_valid & r_is_load & (r_rd_addr != '0) & bus.in_valid_i &
                      ((w_rs1_addr == r_rd_addr) | (w_rs2_addr == r_rd_addr));
  assign w_in_ready = (~r_out_valid | bus.out_ready_i) & ~w_hazard & ~bus.flush_i;
  assign w_capture  = bus.in_valid_i & w_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_inst_addr <= '0;
      r_inst      <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_rs2_data  <= '0;
      r_rd_addr   <= '0;
      r_reg_wen   <= 1'b0;
      r_is_load   <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (bus.flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_inst_addr <= bus.inst_addr_i;
      r_inst      <= bus.inst_i;
      r_op1       <= w_illegal ? '0 : w_op1;
      r_op2       <= w_illegal ? '0 : w_op2;
      r_imm       <= w_illegal ? '0 : w_imm;
      r_rs2_data  <= w_illegal ? '0 : bus.rs2_data_i;
      r_rd_addr   <= w_rd_addr;
      r_reg_wen   <= w_reg_wen;
      r_is_load   <= w_is_load & ~w_illegal;
      r_illegal   <= w_illegal;
    end else if (bus.out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.rs1_addr_o  = w_rs1_addr;
  assign bus.rs2_addr_o  = w_rs2_addr;
  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = r_out_valid;
  assign bus.inst_addr_o = r_inst_addr;
  assign bus.inst_o      = r_inst;
  assign bus.op1_o       = r_op1;
  assign bus.op2_o       = r_op2;
  assign bus.imm_o       = r_imm;
  assign bus.rs2_data_o  = r_rs2_data;
  assign bus.rd_addr_o   = r_rd_addr;
  assign bus.reg_wen_o   = r_reg_wen;
  assign bus.is_load_o   = r_is_load;
  assign bus.illegal_o   = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Brief    : Randomised scoreboard bench for id_stage against an ISA-level model.
// Revision : 1.0
// ============================================================================
module tb_id_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();
  id_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] rf [32];
  assign bus.rs1_data_i = rf[bus.rs1_addr_o];
  assign bus.rs2_data_i = rf[bus.rs2_addr_o];

  typedef struct {
    logic [31:0] pc, inst, op1, op2, imm, rs2d;
    logic [4:0]  rd, rs1a, rs2a;
    logic        wen, ld, ill;
  } exp_t;

  exp_t        q[$];
  exp_t        m_cur;
  exp_t        mon_e;
  logic        m_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pc = '0;
  logic        last_ov, last_rdy, last_took = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ISA-level decode: fields and immediates are built with integer arithmetic
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] ipc);
    exp_t        e;
    int          s;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, r1, r2;
    bit          has_rd, has_r1, has_r2;
    s     = int'(inst);
    i_imm = 32'(s >>> 20);
    s_imm = 32'((s >>> 25) * 32) + 32'(inst[11:7]);
    b_imm = 32'((s >>> 31) * 4096) + 32'(inst[7]) * 2048 + 32'(inst[30:25]) * 32
            + 32'(inst[11:8]) * 2;
    u_imm = inst & 32'hFFFF_F000;
    j_imm = 32'((s >>> 31) * 1048576) + 32'(inst[19:12]) * 4096 + 32'(inst[20]) * 2048
            + 32'(inst[30:21]) * 2;
    shamt = 32'(inst[24:20]);
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    rd = inst[11:7]; r1 = inst[19:15]; r2 = inst[24:20];
    has_rd = 0; has_r1 = 0; has_r2 = 0;
    e = '{default: '0};
    e.pc = ipc; e.inst = inst;
    case (opc)
      7'h33: begin
        has_rd = 1; has_r1 = 1; has_r2 = 1;
        e.op1 = rf[r1]; e.op2 = rf[r2];
        e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        has_rd = 1; has_r1 = 1;
        e.imm = i_imm; e.op1 = rf[r1];
        if (f3 == 1) begin e.op2 = shamt; e.ill = (f7 != 0); end
        else if (f3 == 5) begin e.op2 = shamt; e.ill = (f7 != 0 && f7 != 7'h20); end
        else e.op2 = i_imm;
      end
      7'h03: begin
        has_rd = 1; has_r1 = 1;
        e.imm = i_imm; e.op1 = rf[r1]; e.op2 = i_imm;
        e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        has_r1 = 1; has_r2 = 1;
        e.imm = s_imm; e.op1 = rf[r1]; e.op2 = s_imm; e.ill = (f3 > 2);
      end
      7'h63: begin
        has_r1 = 1; has_r2 = 1;
        e.imm = b_imm; e.op1 = rf[r1]; e.op2 = rf[r2]; e.ill = (f3 == 2 || f3 == 3);
      end
      7'h37: begin has_rd = 1; e.imm = u_imm; e.op2 = u_imm; end
      7'h17: begin has_rd = 1; e.imm = u_imm; e.op1 = ipc; e.op2 = u_imm; end
      7'h6F: begin has_rd = 1; e.imm = j_imm; e.op1 = ipc; e.op2 = 4; end
      7'h67: begin
        has_rd = 1; has_r1 = 1;
        e.imm = i_imm; e.op1 = ipc; e.op2 = 4; e.ill = (f3 != 0);
      end
      default: e.ill = 1;
    endcase
    e.rs1a = has_r1 ? r1 : 5'd0;
    e.rs2a = has_r2 ? r2 : 5'd0;
    e.rd   = has_rd ? rd : 5'd0;
    e.wen  = has_rd && !e.ill && rd != 0;
    e.ld   = (opc == 7'h03) && !e.ill;
    e.rs2d = rf[e.rs2a];
    if (e.ill) begin e.op1 = 0; e.op2 = 0; e.imm = 0; e.rs2d = 0; end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                               7'h67, 7'h73};
    logic [6:0]  opc, f7;
    logic [31:0] w;
    if ($urandom_range(0, 15) == 0) return $urandom;
    opc = opcs[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      1:       f7 = 7'h20;
      3:       f7 = 7'($urandom);
      default: f7 = 7'h00;
    endcase
    w = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
         5'($urandom_range(0, 3)), opc};
    if (opc == 7'h03 || opc == 7'h67 || (opc == 7'h13 && w[13:12] != 2'b01))
      w[31:20] = 12'($urandom);
    else if (opc == 7'h37 || opc == 7'h17 || opc == 7'h6F)
      w[31:12] = 20'($urandom);
    else if (opc == 7'h23 || opc == 7'h63)
      w[31:25] = 7'($urandom);
    return w;
  endfunction

  // One clock of stimulus; the expected handshake comes from the model's own pipeline state
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    exp_t e;
    bit   hz, exp_rdy;
    bus.in_valid_i  = v;
    bus.inst_i      = ins;
    bus.inst_addr_i = pc;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    @(negedge clk);
    e        = model(ins, pc);
    last_ov  = bus.out_valid_o;
    last_rdy = bus.in_ready_o;
    chk("out_valid", 32'(bus.out_valid_o), 32'(m_valid));
    chk("rs1_addr", 32'(bus.rs1_addr_o), 32'(e.rs1a));
    chk("rs2_addr", 32'(bus.rs2_addr_o), 32'(e.rs2a));
    hz = m_valid && m_cur.ld && m_cur.rd != 0 && v &&
         ((e.rs1a != 0 && e.rs1a == m_cur.rd) || (e.rs2a != 0 && e.rs2a == m_cur.rd));
    exp_rdy = (!m_valid || ordy) && !hz && !fl;
    chk("in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
    last_took = v && exp_rdy;
    if (last_took) q.push_back(e);
    if (fl) m_valid = 1'b0;
    else if (last_took) begin m_valid = 1'b1; m_cur = e; end
    else if (ordy) m_valid = 1'b0;
    if (last_took) pc = pc + 4;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got inst %0h, expected none", bus.inst_o);
        end else begin
          mon_e = q.pop_front();
          chk("pc_o", bus.inst_addr_o, mon_e.pc);
          chk("inst_o", bus.inst_o, mon_e.inst);
          chk("op1", bus.op1_o, mon_e.op1);
          chk("op2", bus.op2_o, mon_e.op2);
          chk("imm", bus.imm_o, mon_e.imm);
          chk("rs2_data", bus.rs2_data_o, mon_e.rs2d);
          chk("rd_addr", 32'(bus.rd_addr_o), 32'(mon_e.rd));
          chk("reg_wen", 32'(bus.reg_wen_o), 32'(mon_e.wen));
          chk("is_load", 32'(bus.is_load_o), 32'(mon_e.ld));
          chk("illegal", 32'(bus.illegal_o), 32'(mon_e.ill));
        end
      end else if (bus.out_valid_o && bus.flush_i && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] cur, snap_op1, snap_op2;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
    rf[1] = 32'd5;
    bus.in_valid_i = 0; bus.inst_i = '0; bus.inst_addr_i = '0;
    bus.out_ready_i = 0; bus.flush_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 0);
    chk("rst_reg_wen", 32'(bus.reg_wen_o), 0);
    chk("rst_is_load", 32'(bus.is_load_o), 0);
    chk("rst_illegal", 32'(bus.illegal_o), 0);
    chk("rst_op1", bus.op1_o, 0);
    chk("rst_inst_o", bus.inst_o, 0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x1,-1 with x1 = 5
    pc = 32'h0;
    step(1, 32'hFFF08093, 1, 0);
    chk("addi_op1", bus.op1_o, 32'd5);
    chk("addi_op2", bus.op2_o, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(bus.rd_addr_o), 1);
    chk("addi_wen", 32'(bus.reg_wen_o), 1);
    pc = 32'h100;
    step(1, 32'h12345117, 1, 0);
    chk("auipc_op1", bus.op1_o, 32'h100);
    chk("auipc_op2", bus.op2_o, 32'h1234_5000);
    pc = 32'h200;
    step(1, 32'h008000EF, 1, 0);
    chk("jal_op1", bus.op1_o, 32'h200);
    chk("jal_op2", bus.op2_o, 32'd4);
    chk("jal_imm", bus.imm_o, 32'd8);
    step(0, '0, 1, 0);

    // lw x5,0(x1) then add x6,x5,x5
    step(1, 32'h0000A283, 1, 0);
    step(1, 32'h00528333, 1, 0);
    chk("lu_valid0", 32'(last_ov), 1);
    chk("lu_stall", 32'(last_took), 0);
    step(1, 32'h00528333, 1, 0);
    chk("lu_valid1", 32'(last_ov), 0);
    step(0, '0, 1, 0);
    chk("lu_valid2", 32'(last_ov), 1);
    chk("lu_inst", bus.inst_o, 32'h00528333);

    // backpressure on addi x3,x2,7 while add x4,x3,x3 waits
    step(1, 32'h00710193, 1, 0);
    snap_op1 = bus.op1_o;
    snap_op2 = bus.op2_o;
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00318233, 0, 0);
      chk("bp_in_ready", 32'(last_rdy), 0);
      chk("bp_inst_hold", bus.inst_o, 32'h00710193);
      chk("bp_op1_hold", bus.op1_o, snap_op1);
      chk("bp_op2_hold", bus.op2_o, snap_op2);
    end
    step(1, 32'h00318233, 1, 0);
    step(0, '0, 1, 0);
    chk("bp_next_valid", 32'(last_ov), 1);

    // flush alongside a valid input
    step(1, 32'h00710193, 1, 1);
    chk("flush_no_take", 32'(last_rdy), 0);
    step(0, '0, 1, 0);
    chk("flush_valid", 32'(last_ov), 0);

    step(1, 32'hFFFF_FFFF, 1, 0);
    chk("ill_flag", 32'(bus.illegal_o), 1);
    chk("ill_wen", 32'(bus.reg_wen_o), 0);
    step(0, '0, 1, 0);

    cur = rand_inst();
    for (int i = 0; i < 400; i++) begin
      if (last_took) cur = rand_inst();
      step($urandom_range(0, 9) < 8, cur, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end

    // asynchronous reset while an instruction is held
    step(1, 32'h00710193, 0, 0);
    step(0, '0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid_o), 0);
    chk("arst_reg_wen", 32'(bus.reg_wen_o), 0);
    chk("arst_op1", bus.op1_o, 0);
    chk("arst_op2", bus.op2_o, 0);
    chk("arst_inst_o", bus.inst_o, 0);
    chk("arst_pc_o", bus.inst_addr_o, 0);
    q.delete();
    m_valid = 1'b0;
    bus.in_valid_i = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    cur = rand_inst();
    for (int i = 0; i < 60; i++) begin
      if (last_took) cur = rand_inst();
      step($urandom_range(0, 9) < 8, cur, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (3) step(0, '0, 1, 0);
    chk("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
